audio_filter_seq: RTL and testbench



---
 rtl/audio_filter_seq.sv | 200 ++++++++++++++++++++
 tb/tb_audio_filter_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_filter_seq.sv
// Configuration sequencer for the audio filter chain: shadow coefficient registers,
// mute fade-out, atomic coefficient swap, filter settle hold and fade-in.
module audio_filter_seq #(
    parameter int          RAMP_DIV       = 4,
    parameter int          SETTLE_SAMPLES = 256,
    parameter logic [31:0] DEF_FLT_RATE   = 32'd7056000,
    parameter logic [39:0] DEF_CX         = 40'd4258969,
    parameter logic [7:0]  DEF_CX0        = 8'd3,
    parameter logic [7:0]  DEF_CX1        = 8'd3,
    parameter logic [7:0]  DEF_CX2        = 8'd1,
    parameter logic [23:0] DEF_CY0        = -24'd6216759,
    parameter logic [23:0] DEF_CY1        = 24'd6143386,
    parameter logic [23:0] DEF_CY2        = -24'd2023767
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_ce,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        commit,
    input  logic [4:0]  user_att,
    output logic [31:0] flt_rate,
    output logic [39:0] cx,
    output logic [7:0]  cx0,
    output logic [7:0]  cx1,
    output logic [7:0]  cx2,
    output logic [23:0] cy0,
    output logic [23:0] cy1,
    output logic [23:0] cy2,
    output logic [4:0]  att,
    output logic        flt_reset,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, FADE_OUT, SWAP, SETTLE, FADE_IN} state_t;

    localparam int SW = $clog2(RAMP_DIV) + 1;
    localparam int CW = $clog2(SETTLE_SAMPLES) + 1;

    state_t        state, state_next;
    logic [4:0]    lvl, lvl_next;
    logic [SW-1:0] step_cnt, step_next;
    logic [CW-1:0] settle_cnt, settle_next;
    logic          pending, pending_next;
    logic          flt_reset_next, done_next;
    logic          ramp_tick;
    logic [4:0]    att_next;

    logic [31:0]   sh_rate;
    logic [39:0]   sh_cx;
    logic [7:0]    sh_cx0, sh_cx1, sh_cx2;
    logic [23:0]   sh_cy0, sh_cy1, sh_cy2;

    assign busy      = (state != IDLE);
    assign ramp_tick = sample_ce && (step_cnt == SW'(RAMP_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lvl        <= '0;
            step_cnt   <= '0;
            settle_cnt <= '0;
            pending    <= 1'b0;
            flt_reset  <= 1'b0;
            done       <= 1'b0;
            att        <= user_att;
        end else begin
            state      <= state_next;
            lvl        <= lvl_next;
            step_cnt   <= step_next;
            settle_cnt <= settle_next;
            pending    <= pending_next;
            flt_reset  <= flt_reset_next;
            done       <= done_next;
            att        <= att_next;
        end
    end

    always_comb begin
        state_next     = state;
        lvl_next       = lvl;
        step_next      = step_cnt;
        settle_next    = settle_cnt;
        pending_next   = pending | commit;
        flt_reset_next = flt_reset;
        done_next      = 1'b0;
        case (state)
            IDLE: begin
                lvl_next     = '0;
                pending_next = 1'b0;
                if (commit || pending)
                    state_next = FADE_OUT;
            end
            FADE_OUT: begin
                if (ramp_tick) begin
                    step_next = '0;
                    lvl_next  = lvl + 5'd1;
                    if (lvl == 5'd15)
                        state_next = SWAP;
                end else if (sample_ce) begin
                    step_next = step_cnt + SW'(1);
                end
            end
            SWAP: begin
                flt_reset_next = 1'b1;
                state_next     = SETTLE;
            end
            SETTLE: begin
                if (sample_ce) begin
                    settle_next = settle_cnt + CW'(1);
                    if (settle_cnt == CW'(SETTLE_SAMPLES - 1)) begin
                        flt_reset_next = 1'b0;
                        state_next     = FADE_IN;
                    end
                end
            end
            FADE_IN: begin
                if (ramp_tick) begin
                    step_next = '0;
                    lvl_next  = lvl - 5'd1;
                    if (lvl == 5'd1) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else if (sample_ce) begin
                    step_next = step_cnt + SW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // Every state starts counting its own sample pulses from zero.
        if (state_next != state) begin
            step_next   = '0;
            settle_next = '0;
        end
    end

    always_comb begin
        att_next = user_att;
        if (lvl == 5'd16) begin
            att_next = 5'h1F;
        end else if (lvl[3:0] > user_att[3:0]) begin
            att_next[3:0] = lvl[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_rate <= DEF_FLT_RATE;
            sh_cx   <= DEF_CX;
            sh_cx0  <= DEF_CX0;
            sh_cx1  <= DEF_CX1;
            sh_cx2  <= DEF_CX2;
            sh_cy0  <= DEF_CY0;
            sh_cy1  <= DEF_CY1;
            sh_cy2  <= DEF_CY2;
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0: sh_rate       <= cfg_data;
                3'd1: sh_cx[31:0]   <= cfg_data;
                3'd2: sh_cx[39:32]  <= cfg_data[7:0];
                3'd3: begin
                    sh_cx0 <= cfg_data[7:0];
                    sh_cx1 <= cfg_data[15:8];
                    sh_cx2 <= cfg_data[23:16];
                end
                3'd4: sh_cy0 <= cfg_data[23:0];
                3'd5: sh_cy1 <= cfg_data[23:0];
                3'd6: sh_cy2 <= cfg_data[23:0];
                default: ;
            endcase
        end
    end

    // Live set is loaded from the pre-write shadow values, so a write in SWAP lands in shadow only.
    always_ff @(posedge clk) begin
        if (reset) begin
            flt_rate <= DEF_FLT_RATE;
            cx       <= DEF_CX;
            cx0      <= DEF_CX0;
            cx1      <= DEF_CX1;
            cx2      <= DEF_CX2;
            cy0      <= DEF_CY0;
            cy1      <= DEF_CY1;
            cy2      <= DEF_CY2;
        end else if (state == SWAP) begin
            flt_rate <= sh_rate;
            cx       <= sh_cx;
            cx0      <= sh_cx0;
            cx1      <= sh_cx1;
            cx2      <= sh_cx2;
            cy0      <= sh_cy0;
            cy1      <= sh_cy1;
            cy2      <= sh_cy2;
        end
    end

endmodule

// File: tb/tb_audio_filter_seq.sv
// Self-checking bench for audio_filter_seq: random shadow data and sample spacing,
// compared every cycle against a pulse-counting reference model.
module tb_audio_filter_seq;

    localparam int RD = 1;
    localparam int SS = 4;
    localparam logic [31:0] D_RATE = 32'd7056000;
    localparam logic [39:0] D_CX   = 40'd4258969;
    localparam logic [7:0]  D_CX0 = 8'd3, D_CX1 = 8'd3, D_CX2 = 8'd1;
    localparam logic [23:0] D_CY0 = -24'd6216759, D_CY1 = 24'd6143386, D_CY2 = -24'd2023767;
    localparam int P_IDLE = 0, P_OUT = 1, P_SWAP = 2, P_SETTLE = 3, P_IN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_ce = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        commit = 1'b0;
    logic [4:0]  user_att = 5'h03;
    logic [31:0] flt_rate;
    logic [39:0] cx;
    logic [7:0]  cx0, cx1, cx2;
    logic [23:0] cy0, cy1, cy2;
    logic [4:0]  att;
    logic        flt_reset, busy, done;

    audio_filter_seq #(.RAMP_DIV(RD), .SETTLE_SAMPLES(SS)) dut (
        .clk(clk), .reset(reset), .sample_ce(sample_ce), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .commit(commit), .user_att(user_att),
        .flt_rate(flt_rate), .cx(cx), .cx0(cx0), .cx1(cx1), .cx2(cx2),
        .cy0(cy0), .cy1(cy1), .cy2(cy2), .att(att), .flt_reset(flt_reset),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;
    int ce_gap = 0;
    int done_seen = 0;

    int          m_phase, m_pulses, m_lvl;
    bit          m_pend, m_frst, m_done;
    logic [4:0]  m_att;
    logic [31:0] m_rate, s_rate;
    logic [39:0] m_cx, s_cx;
    logic [7:0]  m_cx0, m_cx1, m_cx2, s_cx0, s_cx1, s_cx2;
    logic [23:0] m_cy0, m_cy1, m_cy2, s_cy0, s_cy1, s_cy2;

    function automatic logic [4:0] att_of(int l, logic [4:0] u);
        int hi;
        if (l == 16) return 5'h1F;
        hi = (int'(u[3:0]) > l) ? int'(u[3:0]) : l;
        return {u[4], 4'(hi)};
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_pulses = 0; m_lvl = 0;
        m_pend = 0; m_frst = 0; m_done = 0;
        m_rate = D_RATE; m_cx = D_CX; m_cx0 = D_CX0; m_cx1 = D_CX1; m_cx2 = D_CX2;
        m_cy0 = D_CY0; m_cy1 = D_CY1; m_cy2 = D_CY2;
        s_rate = D_RATE; s_cx = D_CX; s_cx0 = D_CX0; s_cx1 = D_CX1; s_cx2 = D_CX2;
        s_cy0 = D_CY0; s_cy1 = D_CY1; s_cy2 = D_CY2;
    endtask

    // Advances the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic [4:0] na;
        if (reset) begin
            model_reset();
            m_att = user_att;
            return;
        end
        na = att_of(m_lvl, user_att);
        m_done = 0;
        if (m_phase == P_SWAP) begin
            m_rate = s_rate; m_cx = s_cx; m_cx0 = s_cx0; m_cx1 = s_cx1; m_cx2 = s_cx2;
            m_cy0 = s_cy0; m_cy1 = s_cy1; m_cy2 = s_cy2;
        end
        if (cfg_we) begin
            case (cfg_addr)
                3'd0: s_rate = cfg_data;
                3'd1: s_cx[31:0] = cfg_data;
                3'd2: s_cx[39:32] = cfg_data[7:0];
                3'd3: begin s_cx0 = cfg_data[7:0]; s_cx1 = cfg_data[15:8]; s_cx2 = cfg_data[23:16]; end
                3'd4: s_cy0 = cfg_data[23:0];
                3'd5: s_cy1 = cfg_data[23:0];
                3'd6: s_cy2 = cfg_data[23:0];
                default: ;
            endcase
        end
        if (m_phase != P_IDLE && commit) m_pend = 1;
        case (m_phase)
            P_IDLE: if (commit || m_pend) begin m_phase = P_OUT; m_pulses = 0; m_pend = 0; end
            P_OUT: if (sample_ce) begin
                m_pulses++;
                m_lvl = m_pulses / RD;
                if (m_pulses == 16 * RD) m_phase = P_SWAP;
            end
            P_SWAP: begin m_phase = P_SETTLE; m_pulses = 0; m_frst = 1; end
            P_SETTLE: if (sample_ce) begin
                m_pulses++;
                if (m_pulses == SS) begin m_frst = 0; m_phase = P_IN; m_pulses = 0; end
            end
            default: if (sample_ce) begin
                m_pulses++;
                m_lvl = 16 - m_pulses / RD;
                if (m_pulses == 16 * RD) begin m_phase = P_IDLE; m_done = 1; end
            end
        endcase
        m_att = na;
    endtask

    task automatic chk(string tag, logic [39:0] obs, logic [39:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        chk("flt_rate", 40'(flt_rate), 40'(m_rate));
        chk("cx", cx, m_cx);
        chk("cx0", 40'(cx0), 40'(m_cx0));
        chk("cx1", 40'(cx1), 40'(m_cx1));
        chk("cx2", 40'(cx2), 40'(m_cx2));
        chk("cy0", 40'(cy0), 40'(m_cy0));
        chk("cy1", 40'(cy1), 40'(m_cy1));
        chk("cy2", 40'(cy2), 40'(m_cy2));
        chk("att", 40'(att), 40'(m_att));
        chk("flt_reset", 40'(flt_reset), 40'(m_frst));
        chk("busy", 40'(busy), 40'(m_phase != P_IDLE));
        chk("done", 40'(done), 40'(m_done));
    endtask

    // One clock: random sample spacing, edge, model update, then check away from the edge.
    task automatic applyStimulus();
        sample_ce = (ce_gap == 0);
        if (ce_gap == 0) ce_gap = $urandom_range(1, 4);
        else ce_gap--;
        @(posedge clk);
        model_step();
        #1;
        if (done) done_seen++;
        checkOutput();
        commit = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic do_write(logic [2:0] a, logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        applyStimulus();
    endtask

    task automatic wait_phase(int target, int max_cyc);
        int c = 0;
        while (m_phase != target && c < max_cyc) begin applyStimulus(); c++; end
        chk("wait_phase_timeout", 40'(m_phase), 40'(target));
    endtask

    task automatic run_idle(int max_cyc);
        int c = 0;
        while ((m_phase != P_IDLE || m_pend) && c < max_cyc) begin applyStimulus(); c++; end
        chk("run_idle_timeout", 40'(c < max_cyc), 40'd1);
    endtask

    initial begin
        logic [31:0] rnd_cx;
        logic [23:0] cy1_a, cy1_b;
        model_reset();
        m_att = 5'h03;

        // Reset and idle defaults
        reset = 1'b1; user_att = 5'h03;
        repeat (3) applyStimulus();
        reset = 1'b0;
        repeat (4) applyStimulus();
        chk("idle_att", 40'(att), 40'h03);
        chk("idle_rate", 40'(flt_rate), 40'(D_RATE));

        // Basic sequence
        do_write(3'd0, 32'd6000000);
        do_write(3'd4, 32'h00123456);
        do_write(3'd3, $urandom);
        do_write(3'd7, $urandom);
        commit = 1'b1;
        applyStimulus();
        done_seen = 0;
        run_idle(600);
        chk("seq1_rate", 40'(flt_rate), 40'd6000000);
        chk("seq1_cy0", 40'(cy0), 40'h123456);
        chk("seq1_done_count", 40'(done_seen), 40'd1);

        // Repeated commits collapse into one pending sequence
        commit = 1'b1;
        applyStimulus();
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            repeat (3) applyStimulus();
            commit = 1'b1;
            applyStimulus();
        end
        wait_phase(P_SETTLE, 400);
        rnd_cx = $urandom;
        do_write(3'd1, rnd_cx);
        run_idle(1500);
        chk("pend_done_count", 40'(done_seen), 40'd2);
        chk("pend_cx_lo", 40'(cx[31:0]), 40'(rnd_cx));

        // Shadow write landing in the SWAP cycle
        cy1_a = 24'($urandom);
        cy1_b = 24'($urandom);
        do_write(3'd5, {8'h00, cy1_a});
        commit = 1'b1;
        applyStimulus();
        wait_phase(P_SWAP, 400);
        do_write(3'd5, {8'h00, cy1_b});
        run_idle(600);
        chk("swap_cy1_old", 40'(cy1), 40'(cy1_a));
        commit = 1'b1;
        applyStimulus();
        run_idle(600);
        chk("swap_cy1_new", 40'(cy1), 40'(cy1_b));

        // Reset in the middle of SETTLE
        do_write(3'd6, $urandom);
        commit = 1'b1;
        applyStimulus();
        wait_phase(P_SETTLE, 400);
        repeat (2) applyStimulus();
        done_seen = 0;
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        chk("rst_rate", 40'(flt_rate), 40'(D_RATE));
        chk("rst_flt_reset", 40'(flt_reset), 40'd0);
        chk("rst_busy", 40'(busy), 40'd0);
        repeat (3) applyStimulus();
        chk("rst_no_done", 40'(done_seen), 40'd0);

        // Host attenuation floor during fade-in, then forced mute bit throughout
        commit = 1'b1;
        applyStimulus();
        wait_phase(P_IN, 600);
        user_att = 5'h0A;
        run_idle(600);
        chk("floor_att", 40'(att), 40'h0A);
        user_att = {1'b1, 4'($urandom)};
        commit = 1'b1;
        applyStimulus();
        run_idle(600);
        applyStimulus();
        chk("mute_att4", 40'(att[4]), 40'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
